// File: rtl/hf_ssp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hf_ssp_pkg : shared types, defaults and helpers for the HF SSP TX block  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hf_ssp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_HALF_DIV = 2;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hf_ssp_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ssp_tx_fifo : word FIFO with combinational head and occupancy count      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ssp_tx_fifo
  import hf_ssp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [level_w(DEPTH)-1:0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [LW-1:0]    cnt_q;
  logic             w_push;
  logic             w_pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/hf_ssp_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hf_ssp_tx : FIFO-buffered MSB-first word serialiser onto the ARM SSP.    |
// | Option: HF_SSP_TX_IDLE_CLK_EN keeps ssp_clk free-running in IDLE.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hf_ssp_tx
  import hf_ssp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic                      ck_1356meg,
  input  logic                      nreset,
  input  logic                      en,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      ssp_clk,
  output logic                      ssp_frame,
  output logic                      ssp_din,
  output logic                      busy,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             frame_q;
  logic             sclk_q;
  logic [DW-1:0]    div_q;

  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_more;
  logic             w_pop;
  logic             w_run;
  logic             w_tc;
  logic             w_rise;

  ssp_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (ck_1356meg),
    .rst_ni  (nreset),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level)
  );

`ifdef HF_SSP_TX_IDLE_CLK_EN
  assign w_run = 1'b1;
`else
  logic start_q;

  // Registered start request gives a fixed HALF_DIV+1 start latency; a high
  // ssp_clk keeps the divider running so the last high half completes.
  assign w_run = (state_q == ST_SHIFT) || sclk_q || start_q;

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) start_q <= 1'b0;
    else         start_q <= (state_q == ST_IDLE) && w_more;
  end
`endif

  assign w_tc   = (div_q == DW'(HALF_DIV - 1));
  assign w_rise = w_run && w_tc && !sclk_q;
  assign w_more = en && !w_empty;
  assign w_pop  = w_rise && w_more && ((state_q == ST_IDLE) || (bit_cnt_q == '0));

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!w_run) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (w_tc) begin
      div_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      frame_q   <= 1'b0;
    end else if (w_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (w_more) begin
            shreg_q   <= w_head;
            frame_q   <= 1'b1;
            bit_cnt_q <= CW'(WIDTH - 1);
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q != '0) begin
            shreg_q   <= shreg_q << 1;
            frame_q   <= 1'b0;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end else if (w_more) begin
            shreg_q   <= w_head;
            frame_q   <= 1'b1;
            bit_cnt_q <= CW'(WIDTH - 1);
          end else begin
            shreg_q   <= '0;
            frame_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Clearing shreg on return to IDLE makes its MSB the idle-low data line.
  assign ssp_din   = shreg_q[WIDTH-1];
  assign ssp_frame = frame_q;
  assign ssp_clk   = sclk_q;
  assign busy      = (state_q == ST_SHIFT);
  assign in_ready  = !w_full;

endmodule
`default_nettype wire

// File: tb/tb_hf_ssp_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hf_ssp_tx : scoreboard bench for hf_ssp_tx (rise-event word capture)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hf_ssp_tx;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int HALF_DIV = 2;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int BIT_P    = 2 * HALF_DIV;
  localparam int WORD_P   = WIDTH * BIT_P;

  logic             clk      = 1'b0;
  logic             nreset   = 1'b0;
  logic             en       = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_ready;
  logic             ssp_clk;
  logic             ssp_frame;
  logic             ssp_din;
  logic             busy;
  logic [LW-1:0]    level;

  hf_ssp_tx #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .HALF_DIV (HALF_DIV)
  ) dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .busy       (busy),
    .level      (level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor: captures words on ssp_clk rise events --------
  typedef struct {
    logic [WIDTH-1:0] word;
    logic             frame_ok;
    logic             busy_ok;
    int               edge_c;
  } rx_t;

  rx_t              rx_mem [64];
  int               rx_wr         = 0;
  int               mon_frames    = 0;
  int               mon_trail_bad = 0;
  int               mon_bitn      = 0;
  int               mon_edge      = 0;
  logic             mon_collect   = 1'b0;
  logic             mon_fok       = 1'b0;
  logic             mon_bok       = 1'b0;
  logic             prev_clk      = 1'b0;
  logic [WIDTH-1:0] mon_word      = '0;

  always @(negedge clk) begin
    prev_clk <= ssp_clk;
    if (!nreset) begin
      mon_collect <= 1'b0;
    end else if (ssp_clk && !prev_clk) begin
      if (ssp_frame) mon_frames <= mon_frames + 1;
      if (ssp_frame && !mon_collect) begin
        mon_fok     <= 1'b1;
        mon_bok     <= busy;
        mon_word    <= {{(WIDTH-1){1'b0}}, ssp_din};
        mon_bitn    <= 1;
        mon_edge    <= cyc;
        mon_collect <= 1'b1;
      end else if (mon_collect) begin
        if (ssp_frame) mon_fok <= 1'b0;
        mon_bok  <= mon_bok & busy;
        mon_word <= {mon_word[WIDTH-2:0], ssp_din};
        mon_bitn <= mon_bitn + 1;
        if (mon_bitn == WIDTH - 1) begin
          rx_mem[rx_wr % 64].word     <= {mon_word[WIDTH-2:0], ssp_din};
          rx_mem[rx_wr % 64].frame_ok <= mon_fok & ~ssp_frame;
          rx_mem[rx_wr % 64].busy_ok  <= mon_bok & busy;
          rx_mem[rx_wr % 64].edge_c   <= mon_edge;
          rx_wr       <= rx_wr + 1;
          mon_collect <= 1'b0;
        end
      end else if (ssp_din) begin
        mon_trail_bad <= mon_trail_bad + 1;
      end
    end
  end

  // ---------------- checker / stimulus ------------------------------------
  int               checks = 0;
  int               errors = 0;
  int               rx_rd  = 0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic acc, output int pedge);
    @(negedge clk);
    chk("in_ready_before_push", 32'(in_ready), 32'(acc));
    in_data  = d;
    in_valid = 1'b1;
    pedge    = cyc + 1;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    while (rx_rd < rx_wr) begin
      rx_t r;
      r = rx_mem[rx_rd % 64];
      rx_rd++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(r.word), 32'hDEAD);
      end else begin
        chk("word", 32'(r.word), 32'(exp_q.pop_front()));
      end
      chk("frame_only_on_msb", 32'(r.frame_ok), 32'd1);
      chk("busy_during_word", 32'(r.busy_ok), 32'd1);
    end
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rx_wr < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rx_wr < target) chk({name, "_timeout"}, 32'(rx_wr), 32'(target));
    drain();
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    int               exp_lat;
  } single_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             exp_acc;
    int               exp_level;
    logic             exp_ready;
  } fill_t;

  single_t singles [5];
  fill_t   fills   [5];

  initial begin
    int pe;
    int tgt;
    int n;
    int zeros;
    int fr0;
    int wr0;

    singles[0] = '{8'hA5, HALF_DIV + 1};
    singles[1] = '{8'h00, HALF_DIV + 1};
    singles[2] = '{8'hFF, HALF_DIV + 1};
    singles[3] = '{8'h5A, HALF_DIV + 1};
    singles[4] = '{8'h3C, HALF_DIV + 1};

    fills[0] = '{8'h11, 1'b1, 1, 1'b1};
    fills[1] = '{8'h22, 1'b1, 2, 1'b1};
    fills[2] = '{8'h33, 1'b1, 3, 1'b1};
    fills[3] = '{8'h44, 1'b1, 4, 1'b0};
    fills[4] = '{8'h55, 1'b0, 4, 1'b0};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ssp_clk",   32'(ssp_clk),   32'd0);
    chk("rst_ssp_din",   32'(ssp_din),   32'd0);
    chk("rst_ssp_frame", 32'(ssp_frame), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    nreset = 1'b1;
    en     = 1'b1;
    repeat (2) @(negedge clk);

    // single words from IDLE
    for (int i = 0; i < 5; i++) begin
      tgt = rx_wr + 1;
      push(singles[i].data, 1'b1, pe);
      wait_rx(tgt, WORD_P + 20, "single");
`ifndef HF_SSP_TX_IDLE_CLK_EN
      chk("start_latency", 32'(rx_mem[(tgt-1) % 64].edge_c - pe), 32'(singles[i].exp_lat));
`else
      chk("start_latency_range",
          32'((rx_mem[(tgt-1) % 64].edge_c - pe >= 1) && (rx_mem[(tgt-1) % 64].edge_c - pe <= BIT_P + 1)),
          32'd1);
`endif
      repeat (BIT_P + 8) @(negedge clk);
`ifndef HF_SSP_TX_IDLE_CLK_EN
      chk("idle_ssp_clk_low", 32'(ssp_clk), 32'd0);
`endif
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // back-to-back words, no gap bit
    tgt = rx_wr + 2;
    push(8'h81, 1'b1, pe);
    push(8'h7E, 1'b1, pe);
    wait_rx(tgt - 1, WORD_P + 20, "b2b_first");
    zeros = 0;
    n = 0;
    while (rx_wr < tgt && n < WORD_P + 20) begin
      @(negedge clk);
      if (!busy) zeros++;
      n++;
    end
    chk("b2b_busy_gaps", 32'(zeros), 32'd0);
    wait_rx(tgt, WORD_P + 20, "b2b_second");
    chk("b2b_word_spacing",
        32'(rx_mem[(tgt-1) % 64].edge_c - rx_mem[(tgt-2) % 64].edge_c), 32'(WORD_P));
    repeat (BIT_P + 8) @(negedge clk);

    // fill to full with en low, fifth push refused
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(fills[i].data, fills[i].exp_acc, pe);
      chk("fill_level",    32'(level),    32'(fills[i].exp_level));
      chk("fill_in_ready", 32'(in_ready), 32'(fills[i].exp_ready));
    end
    repeat (10) @(negedge clk);
    chk("full_no_tx_frames", 32'(busy), 32'd0);
    tgt = rx_wr + 4;
    en  = 1'b1;
    wait_rx(tgt, 4 * WORD_P + 40, "full_drain");
    repeat (BIT_P + 8) @(negedge clk);
    chk("full_drained_level", 32'(level), 32'd0);

    // en dropped mid-word
    tgt = rx_wr + 1;
    push(8'h3C, 1'b1, pe);
    push(8'hC3, 1'b1, pe);
    n = 0;
    while (!mon_collect && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("endrop_word_started", 32'(mon_collect), 32'd1);
    en = 1'b0;
    wait_rx(tgt, WORD_P + 20, "endrop_first");
    repeat (40) @(negedge clk);
    chk("endrop_level_held", 32'(level), 32'd1);
    chk("endrop_busy_low",   32'(busy),  32'd0);
    chk("endrop_no_second",  32'(rx_wr), 32'(tgt));
    en = 1'b1;
    wait_rx(tgt + 1, WORD_P + 20, "endrop_resume");
    repeat (BIT_P + 8) @(negedge clk);

    // asynchronous reset in the middle of a word
    push(8'hFF, 1'b1, pe);
    push(8'h55, 1'b1, pe);
    n = 0;
    while (!(mon_collect && mon_bitn == 3) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reached_bit3", 32'(mon_bitn), 32'd3);
    #2 nreset = 1'b0;
    #1;
    chk("rstmid_ssp_clk",   32'(ssp_clk),   32'd0);
    chk("rstmid_ssp_din",   32'(ssp_din),   32'd0);
    chk("rstmid_ssp_frame", 32'(ssp_frame), 32'd0);
    chk("rstmid_busy",      32'(busy),      32'd0);
    chk("rstmid_level",     32'(level),     32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    fr0 = mon_frames;
    wr0 = rx_wr;
    nreset = 1'b1;
    repeat (60) @(negedge clk);
    chk("rstmid_no_frames_after", 32'(mon_frames), 32'(fr0));
    chk("rstmid_no_words_after",  32'(rx_wr),      32'(wr0));
    chk("idle_rise_data_low",     32'(mon_trail_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
